// File: rtl/mult_pkg.sv
// Shared definitions for the sequential MULT/MULTU controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mult_pkg;

    // Operand width used when the parent does not override WIDTH.
    localparam int MULT_WIDTH_DEF = 32;

    // Width of the iteration counter for the default operand width.
    localparam int MULT_CNT_W = $clog2(MULT_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mult_state_e;

    // Counter width for an arbitrary operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_acc_adder.sv
// Purpose: WIDTH-bit carry-select adder (sum = a + b + cin) for the product accumulator.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b addends; i_cin carry in; o_sum result; o_cout carry out.
module mult_acc_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int LO_W = WIDTH / 2;
    localparam int HI_W = WIDTH - LO_W;

    logic [LO_W:0] w_lo;
    logic [HI_W:0] w_hi_c0;
    logic [HI_W:0] w_hi_c1;

    // Lower half ripples from i_cin; upper half is evaluated for both possible
    // carries in parallel and picked by the lower half's carry out.
    assign w_lo    = {1'b0, i_a[LO_W-1:0]} + {1'b0, i_b[LO_W-1:0]} + {{LO_W{1'b0}}, i_cin};
    assign w_hi_c0 = {1'b0, i_a[WIDTH-1:LO_W]} + {1'b0, i_b[WIDTH-1:LO_W]};
    assign w_hi_c1 = {1'b0, i_a[WIDTH-1:LO_W]} + {1'b0, i_b[WIDTH-1:LO_W]} + {{HI_W{1'b0}}, 1'b1};

    assign o_sum  = {(w_lo[LO_W] ? w_hi_c1[HI_W-1:0] : w_hi_c0[HI_W-1:0]), w_lo[LO_W-1:0]};
    assign o_cout = w_lo[LO_W] ? w_hi_c1[HI_W] : w_hi_c0[HI_W];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Purpose: shift-add sequencer for MULT/MULTU producing a 2*WIDTH-bit product on hi/lo.
// Latency: start accepted in cycle N -> done in N+WIDTH+2 (earlier with MULT_EARLY_EXIT_EN).
// Backpressure: start ignored while busy; accepted again in IDLE or in the DONE cycle.
// Ports: clk, reset (sync, active-high), start, signed_op, op_a, op_b -> busy, done, hi, lo.
// Build option: define MULT_EARLY_EXIT_EN to leave CALC as soon as the multiplier is exhausted.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(WIDTH - 1);

    mult_state_e        r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_count;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_add_a;
    logic [2*WIDTH-1:0] w_add_b;
    logic               w_add_cin;
    logic [2*WIDTH-1:0] w_sum;
    logic               w_cout_unused;
    logic               w_early;

    // Magnitudes: the most negative value maps onto itself, which is the
    // correct unsigned magnitude, so no special case is needed.
    assign w_a_neg = signed_op & op_a[WIDTH-1];
    assign w_b_neg = signed_op & op_b[WIDTH-1];
    assign w_a_mag = w_a_neg ? (~op_a + WIDTH'(1)) : op_a;
    assign w_b_mag = w_b_neg ? (~op_b + WIDTH'(1)) : op_b;

`ifdef MULT_EARLY_EXIT_EN
    assign w_early = (r_mplier == '0);
`else
    assign w_early = 1'b0;
`endif

    // One adder serves both phases: CALC accumulates the (possibly gated)
    // multiplicand, FIX negates the accumulator as ~acc + 1.
    always_comb begin
        w_add_a   = r_acc;
        w_add_b   = r_mplier[0] ? r_mcand : '0;
        w_add_cin = 1'b0;
        if (r_state == ST_FIX) begin
            w_add_a   = ~r_acc;
            w_add_b   = '0;
            w_add_cin = 1'b1;
        end
    end

    mult_acc_adder #(
        .WIDTH (2 * WIDTH)
    ) u_adder (
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout_unused)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
                        r_mplier <= w_b_mag;
                        r_neg    <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        r_acc    <= '0;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end else begin
                        r_state  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    if (w_early) begin
                        r_state <= ST_FIX;
                    end else begin
                        // Adder input is already zero when mplier[0] is clear.
                        r_acc    <= w_sum;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + CNT_W'(1);
                        if (r_count == LAST) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (r_neg) begin
                        r_acc <= w_sum;
                    end
                    {r_hi, r_lo} <= r_neg ? w_sum : r_acc;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl: products, done timing, back-to-back starts, reset abort.
module tb_mult_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mult_seq_ctrl #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    // Expected cycle offset of done relative to the start cycle.
    function automatic int exp_lat(input logic sop, input logic [31:0] b);
        logic [31:0] m;
        int          idx;
        m   = (sop && b[31]) ? (~b + 32'd1) : b;
        idx = -1;
        for (int i = 0; i < 32; i++) if (m[i]) idx = i;
`ifdef MULT_EARLY_EXIT_EN
        if (idx < 0) return 3;
        return (idx + 4 > 34) ? 34 : idx + 4;
`else
        return (idx >= -1) ? 34 : 34;
`endif
    endfunction

    // Issue one operation from IDLE and measure when done appears (-1 on timeout).
    task automatic do_op(input logic sop, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy1, output logic busy_d,
                         output logic done_nx);
        @(negedge clk);
        signed_op = sop; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        lat = -1; busy1 = busy; busy_d = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                lat = k; busy_d = busy;
                break;
            end
        end
        @(negedge clk);
        done_nx = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signed_op = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_cmp++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        reset = 1'b0;
    endtask

    task automatic test_multu_max();
        int lat; logic b1, bd, dn;
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, b1, bd, dn);
        n_cmp++; if (lat !== exp_lat(1'b0, 32'hFFFF_FFFF)) begin n_fail++; $display("FAIL max_latency got %0d want %0d", lat, exp_lat(1'b0, 32'hFFFF_FFFF)); end
        n_cmp++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL max_hi got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL max_lo got %h want 00000001", lo); end
        n_cmp++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL max_busy_start got %b want 1", b1); end
        n_cmp++; if (bd !== 1'b0) begin n_fail++; $display("FAIL max_busy_at_done got %b want 0", bd); end
        n_cmp++; if (dn !== 1'b0) begin n_fail++; $display("FAIL max_done_pulse_width got %b want 0", dn); end
    endtask

    task automatic test_signed();
        int lat; logic b1, bd, dn;
        do_op(1'b1, 32'hFFFF_FFFD, 32'd7, lat, b1, bd, dn);
        n_cmp++; if (lat !== exp_lat(1'b1, 32'd7)) begin n_fail++; $display("FAIL mult_neg3x7_latency got %0d want %0d", lat, exp_lat(1'b1, 32'd7)); end
        n_cmp++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg3x7_hi got %h want ffffffff", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_neg3x7_lo got %h want ffffffeb", lo); end
        do_op(1'b0, 32'hFFFF_FFFD, 32'd7, lat, b1, bd, dn);
        n_cmp++; if (hi !== 32'h0000_0006) begin n_fail++; $display("FAIL multu_fffffffdx7_hi got %h want 00000006", hi); end
        n_cmp++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL multu_fffffffdx7_lo got %h want ffffffeb", lo); end
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, b1, bd, dn);
        n_cmp++; if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL mult_minneg_hi got %h want 40000000", hi); end
        n_cmp++; if (lo !== 32'h0000_0000) begin n_fail++; $display("FAIL mult_minneg_lo got %h want 00000000", lo); end
        n_cmp++; if (lat !== exp_lat(1'b1, 32'h8000_0000)) begin n_fail++; $display("FAIL mult_minneg_latency got %0d want %0d", lat, exp_lat(1'b1, 32'h8000_0000)); end
    endtask

    task automatic test_short_ops();
        int lat; logic b1, bd, dn;
        do_op(1'b0, 32'd9, 32'd3, lat, b1, bd, dn);
        n_cmp++; if (lat !== exp_lat(1'b0, 32'd3)) begin n_fail++; $display("FAIL 9x3_latency got %0d want %0d", lat, exp_lat(1'b0, 32'd3)); end
        n_cmp++; if ({hi, lo} !== 64'd27) begin n_fail++; $display("FAIL 9x3_product got %h_%h want 27", hi, lo); end
        do_op(1'b0, 32'd1234, 32'd0, lat, b1, bd, dn);
        n_cmp++; if (lat !== exp_lat(1'b0, 32'd0)) begin n_fail++; $display("FAIL 1234x0_latency got %0d want %0d", lat, exp_lat(1'b0, 32'd0)); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL 1234x0_product got %h_%h want 0", hi, lo); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, lat1, lat2;
        logic [31:0] lo1, hi1, lo2, hi2, lo_mid;
        logic busy_mid;
        lat1 = exp_lat(1'b0, 32'd6);
        lat2 = exp_lat(1'b0, 32'h10);
        d1 = -1; d2 = -1; lo1 = 'x; hi1 = 'x; lo2 = 'x; hi2 = 'x; lo_mid = 'x; busy_mid = 1'bx;
        @(negedge clk);
        signed_op = 1'b0; op_a = 32'd5; op_b = 32'd6; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op_a = 32'h10; op_b = 32'h10;
        for (int k = 1; k <= 150; k++) begin
            if (k > 1) @(negedge clk);
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; lo1 = lo; hi1 = hi;
                end else begin
                    d2 = k; lo2 = lo; hi2 = hi;
                    start = 1'b0;
                    break;
                end
            end
            if (d1 > 0 && k == d1 + 3) begin
                lo_mid = lo; busy_mid = busy;
            end
        end
        start = 1'b0;
        n_cmp++; if (d1 !== lat1) begin n_fail++; $display("FAIL b2b_first_latency got %0d want %0d", d1, lat1); end
        n_cmp++; if (lo1 !== 32'd30 || hi1 !== 32'd0) begin n_fail++; $display("FAIL b2b_first_product got %h_%h want 0_1e", hi1, lo1); end
        n_cmp++; if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accepted_busy got %b want 1", busy_mid); end
        n_cmp++; if (lo_mid !== 32'd30) begin n_fail++; $display("FAIL b2b_result_held got %h want 1e", lo_mid); end
        n_cmp++; if (d2 - d1 !== lat2) begin n_fail++; $display("FAIL b2b_done_spacing got %0d want %0d", d2 - d1, lat2); end
        n_cmp++; if (lo2 !== 32'd256 || hi2 !== 32'd0) begin n_fail++; $display("FAIL b2b_second_product got %h_%h want 0_100", hi2, lo2); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_calc();
        int pulses;
        @(negedge clk);
        signed_op = 1'b0; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got %b want 0", done); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL abort_hilo got %h_%h want 0", hi, lo); end
        pulses = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", pulses); end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed();
        test_short_ops();
        test_back_to_back();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
